// File: rtl/pcl_pkg.sv
// Shared constants, write-strobe payload and FSM encoding for the point cloud loader.
package pcl_pkg;

    localparam int unsigned LANES     = 8;
    localparam int unsigned WE_W      = 16;
    localparam int unsigned HDR_ADDR  = 0;
    localparam int unsigned DATA_BASE = 1;

    localparam logic [WE_W-1:0] HDR_WE  = 16'h000f;
    localparam logic [WE_W-1:0] FULL_WE = 16'hffff;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FLUSH  = 2'd2,
        HEADER = 2'd3
    } state_e;

    // Byte write enables for the three coordinate BRAM ports
    typedef struct packed {
        logic [WE_W-1:0] x;
        logic [WE_W-1:0] y;
        logic [WE_W-1:0] z;
    } we_t;

endpackage

// File: rtl/pcl_lane_packer.sv
// Packs accepted points lane by lane into one x/y/z BRAM word; exposes the word
// including the point being pushed so the completing cycle can register it directly.
module pcl_lane_packer
    import pcl_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = pcl_pkg::LANES,
    localparam int unsigned W    = N * LANES,
    localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic [N-1:0]  px,
    input  logic [N-1:0]  py,
    input  logic [N-1:0]  pz,
    output logic [LW-1:0] lane_idx,
    output logic [W-1:0]  word_x_c,
    output logic [W-1:0]  word_y_c,
    output logic [W-1:0]  word_z_c,
    output logic          word_done_c
);

    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [W-1:0] acc_x, acc_y, acc_z;

    // Current buffer with the incoming point merged into its lane
    always_comb begin
        word_x_c    = acc_x;
        word_y_c    = acc_y;
        word_z_c    = acc_z;
        word_done_c = push && (lane_idx == LAST_LANE);
        if (push) begin
            word_x_c[int'(lane_idx) * N +: N] = px;
            word_y_c[int'(lane_idx) * N +: N] = py;
            word_z_c[int'(lane_idx) * N +: N] = pz;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_x    <= '0;
            acc_y    <= '0;
            acc_z    <= '0;
            lane_idx <= '0;
        end else if (clear || word_done_c) begin
            acc_x    <= '0;
            acc_y    <= '0;
            acc_z    <= '0;
            lane_idx <= '0;
        end else if (push) begin
            acc_x    <= word_x_c;
            acc_y    <= word_y_c;
            acc_z    <= word_z_c;
            lane_idx <= lane_idx + LW'(1);
        end
    end

endmodule

// File: rtl/point_cloud_loader.sv
// Streams a LiDAR frame into the x/y/z BRAMs from word 1, then writes the header word 0.
// Optional PCL_ZERO_DROP_EN: all-zero (no-return) points are accepted but discarded.
module point_cloud_loader
    import pcl_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned LANES      = pcl_pkg::LANES,
    parameter int unsigned MAX_POINTS = 8192,
    parameter int unsigned AW         = 32,
    localparam int unsigned W         = N * LANES,
    localparam int unsigned LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            consumer_idle,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N-1:0]    s_x,
    input  logic [N-1:0]    s_y,
    input  logic [N-1:0]    s_z,
    input  logic            s_last,
    output logic [AW-1:0]   addr,
    output logic            en,
    output logic [WE_W-1:0] we_x,
    output logic [WE_W-1:0] we_y,
    output logic [WE_W-1:0] we_z,
    output logic [W-1:0]    wdata_x,
    output logic [W-1:0]    wdata_y,
    output logic [W-1:0]    wdata_z,
    output logic [31:0]     point_count,
    output logic            frame_loaded,
    output logic            overflow
);

    state_e state, next_state;

    logic          accept, full, zero_pt, keep, drop, partial, start, word_wr, pk_clear;
    logic [31:0]   cnt_next;
    logic [AW-1:0] word_ptr;

    logic [LW-1:0] lane_idx;
    logic [W-1:0]  word_x_c, word_y_c, word_z_c;
    logic          word_done_c;

    logic          s_ready_d, en_d, frame_loaded_d;
    logic [AW-1:0] addr_d;
    we_t           we_d;
    logic [W-1:0]  wdata_x_d, wdata_y_d, wdata_z_d;

    assign accept = s_valid && s_ready;
    assign full   = (point_count == 32'(MAX_POINTS));

`ifdef PCL_ZERO_DROP_EN
    assign zero_pt = (s_x == '0) && (s_y == '0) && (s_z == '0);
`else
    assign zero_pt = 1'b0;
`endif

    // Saturated frames still drain: accepted points past capacity only mark overflow
    assign keep     = accept && !full && !zero_pt;
    assign drop     = accept && full;
    assign cnt_next = point_count + 32'(keep);
    assign partial  = keep ? (lane_idx != LW'(LANES - 1)) : (lane_idx != '0);
    assign start    = (state == IDLE) && consumer_idle;
    assign word_wr  = word_done_c || (state == FLUSH);
    assign pk_clear = (state == FLUSH) || (state == IDLE);

    pcl_lane_packer #(
        .N     (N),
        .LANES (LANES)
    ) u_packer (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (pk_clear),
        .push        (keep),
        .px          (s_x),
        .py          (s_y),
        .pz          (s_z),
        .lane_idx    (lane_idx),
        .word_x_c    (word_x_c),
        .word_y_c    (word_y_c),
        .word_z_c    (word_z_c),
        .word_done_c (word_done_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (consumer_idle) next_state = FILL;
            FILL: begin
                if (accept && s_last) begin
                    if (cnt_next == 32'd0) next_state = IDLE;
                    else if (partial)      next_state = FLUSH;
                    else                   next_state = HEADER;
                end
            end
            FLUSH:   next_state = HEADER;
            HEADER:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered BRAM port; writes appear the cycle after the decision
    always_comb begin
        s_ready_d      = (next_state == FILL);
        en_d           = 1'b0;
        addr_d         = '0;
        we_d           = '0;
        wdata_x_d      = wdata_x;
        wdata_y_d      = wdata_y;
        wdata_z_d      = wdata_z;
        frame_loaded_d = 1'b0;
        unique case (state)
            FILL, FLUSH: begin
                if (word_wr) begin
                    en_d      = 1'b1;
                    addr_d    = word_ptr;
                    we_d      = '{x: FULL_WE, y: FULL_WE, z: FULL_WE};
                    wdata_x_d = word_x_c;
                    wdata_y_d = word_y_c;
                    wdata_z_d = word_z_c;
                end
            end
            HEADER: begin
                en_d           = 1'b1;
                addr_d         = AW'(HDR_ADDR);
                we_d           = '{x: HDR_WE, y: HDR_WE, z: '0};
                wdata_x_d      = W'(point_count);
                wdata_y_d      = W'(32'd1);
                wdata_z_d      = '0;
                frame_loaded_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_ready      <= 1'b0;
            en           <= 1'b0;
            addr         <= '0;
            we_x         <= '0;
            we_y         <= '0;
            we_z         <= '0;
            wdata_x      <= '0;
            wdata_y      <= '0;
            wdata_z      <= '0;
            frame_loaded <= 1'b0;
        end else begin
            s_ready      <= s_ready_d;
            en           <= en_d;
            addr         <= addr_d;
            we_x         <= we_d.x;
            we_y         <= we_d.y;
            we_z         <= we_d.z;
            wdata_x      <= wdata_x_d;
            wdata_y      <= wdata_y_d;
            wdata_z      <= wdata_z_d;
            frame_loaded <= frame_loaded_d;
        end
    end

    // Frame counters persist after the header so software can read them
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            point_count <= '0;
            overflow    <= 1'b0;
            word_ptr    <= '0;
        end else if (start) begin
            point_count <= '0;
            overflow    <= 1'b0;
            word_ptr    <= AW'(DATA_BASE);
        end else begin
            if (keep)    point_count <= cnt_next;
            if (drop)    overflow    <= 1'b1;
            if (word_wr) word_ptr    <= word_ptr + AW'(1);
        end
    end

endmodule

// File: tb/tb_point_cloud_loader.sv
// Directed bench for point_cloud_loader (capacity reduced to 16 points); BRAM writes
// are logged on the falling edge and compared against hand-derived words.
module tb_point_cloud_loader;

    localparam int N    = 16;
    localparam int L    = 8;
    localparam int W    = N * L;
    localparam int AW   = 32;
    localparam int MAXP = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          consumer_idle = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [N-1:0]  s_x = '0, s_y = '0, s_z = '0;
    logic          s_ready, en, frame_loaded, overflow;
    logic [AW-1:0] addr;
    logic [15:0]   we_x, we_y, we_z;
    logic [W-1:0]  wdata_x, wdata_y, wdata_z;
    logic [31:0]   point_count;

    int total = 0;
    int bad   = 0;
    int fl_cnt = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   wx, wy, wz;
        logic [W-1:0]  dx, dy, dz;
    } wr_t;
    wr_t log_q[$];

    always #5 clock = ~clock;

    point_cloud_loader #(
        .N(N), .LANES(L), .MAX_POINTS(MAXP), .AW(AW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .consumer_idle(consumer_idle),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_z(s_z),
        .s_last(s_last), .addr(addr), .en(en), .we_x(we_x), .we_y(we_y), .we_z(we_z),
        .wdata_x(wdata_x), .wdata_y(wdata_y), .wdata_z(wdata_z),
        .point_count(point_count), .frame_loaded(frame_loaded), .overflow(overflow)
    );

    always @(negedge clock) begin
        wr_t r;
        if (en) begin
            r.a = addr; r.wx = we_x; r.wy = we_y; r.wz = we_z;
            r.dx = wdata_x; r.dy = wdata_y; r.dz = wdata_z;
            log_q.push_back(r);
        end
        if (frame_loaded) fl_cnt++;
    end

    // Expected packed word: lanes k<cnt hold base+k*step, the rest zero
    function automatic logic [W-1:0] mk_word(input int base, input int step, input int cnt);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < cnt; k++) w[k*N +: N] = N'(base + k * step);
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        consumer_idle = 1'b1;
        for (int i = 0; i < 10 && s_ready !== 1'b1; i++) tick();
        consumer_idle = 1'b0;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_ready got=%b exp=1", s_ready);
        end
    endtask

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] z, input logic last);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b1; s_x = x; s_y = y; s_z = z; s_last = last;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = (s_ready === 1'b1);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout got=no_accept exp=accept");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({s_ready, en, frame_loaded, overflow} !== 4'b0) begin
            bad++;
            $display("FAIL rst_flags got=%b exp=0000", {s_ready, en, frame_loaded, overflow});
        end
        total++;
        if ({addr, point_count, we_x, we_y, we_z} !== '0) begin
            bad++;
            $display("FAIL rst_addr_cnt_we got=%h/%0d exp=0", addr, point_count);
        end
        total++;
        if ({wdata_x, wdata_y, wdata_z} !== '0) begin
            bad++;
            $display("FAIL rst_wdata got=%h exp=0", wdata_x);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle_ready got=%b exp=0", s_ready);
        end
    endtask

    task automatic test_full_words();
        int b;
        b = log_q.size();
        start_frame();
        for (int i = 0; i < 16; i++) send(N'(i + 1), N'(i + 'h101), N'(i + 'h201), i == 15);
        repeat (5) tick();
        total++;
        if (log_q.size() - b !== 3) begin
            bad++;
            $display("FAIL full_nwr got=%0d exp=3", log_q.size() - b);
        end
        for (int j = 0; j < 2 && b + j < log_q.size(); j++) begin
            total++;
            if ({log_q[b+j].a, log_q[b+j].wx, log_q[b+j].wy, log_q[b+j].wz} !==
                {32'(j + 1), 16'hffff, 16'hffff, 16'hffff}) begin
                bad++;
                $display("FAIL full_addr_we%0d got=%0d/%h exp=%0d/ffff", j, log_q[b+j].a, log_q[b+j].wx, j + 1);
            end
            total++;
            if ({log_q[b+j].dx, log_q[b+j].dy, log_q[b+j].dz} !==
                {mk_word(1 + 8*j, 1, 8), mk_word('h101 + 8*j, 1, 8), mk_word('h201 + 8*j, 1, 8)}) begin
                bad++;
                $display("FAIL full_data%0d got=%h exp=%h", j, log_q[b+j].dx, mk_word(1 + 8*j, 1, 8));
            end
        end
        if (b + 2 < log_q.size()) begin
            total++;
            if ({log_q[b+2].a, log_q[b+2].wx, log_q[b+2].wy, log_q[b+2].wz,
                 log_q[b+2].dx[31:0], log_q[b+2].dy[31:0]} !==
                {32'd0, 16'h000f, 16'h000f, 16'h0000, 32'd16, 32'd1}) begin
                bad++;
                $display("FAIL full_header got=a%0d cnt=%0d flag=%0d exp=a0 cnt=16 flag=1",
                         log_q[b+2].a, log_q[b+2].dx[31:0], log_q[b+2].dy[31:0]);
            end
        end
        total++;
        if ({fl_cnt, point_count, overflow} !== {32'd1, 32'd16, 1'b0}) begin
            bad++;
            $display("FAIL full_status got=fl%0d cnt%0d ov%b exp=fl1 cnt16 ov0", fl_cnt, point_count, overflow);
        end
    endtask

    task automatic test_partial_flush();
        int b, f;
        b = log_q.size(); f = fl_cnt;
        start_frame();
        for (int i = 0; i < 10; i++) send(N'(i + 1), N'(i + 'h101), N'(i + 'h201), i == 9);
        repeat (6) tick();
        total++;
        if (log_q.size() - b !== 3) begin
            bad++;
            $display("FAIL part_nwr got=%0d exp=3", log_q.size() - b);
        end
        if (log_q.size() - b >= 3) begin
            total++;
            if ({log_q[b].a, log_q[b].dx, log_q[b].dy, log_q[b].dz} !==
                {32'd1, mk_word(1, 1, 8), mk_word('h101, 1, 8), mk_word('h201, 1, 8)}) begin
                bad++;
                $display("FAIL part_word1 got=a%0d %h exp=a1 %h", log_q[b].a, log_q[b].dx, mk_word(1, 1, 8));
            end
            total++;
            if ({log_q[b+1].a, log_q[b+1].wx, log_q[b+1].wy, log_q[b+1].wz} !==
                {32'd2, 16'hffff, 16'hffff, 16'hffff}) begin
                bad++;
                $display("FAIL part_flush_we got=a%0d we%h exp=a2 weffff", log_q[b+1].a, log_q[b+1].wx);
            end
            total++;
            if ({log_q[b+1].dx, log_q[b+1].dy, log_q[b+1].dz} !==
                {mk_word(9, 1, 2), mk_word('h109, 1, 2), mk_word('h209, 1, 2)}) begin
                bad++;
                $display("FAIL part_flush_data got=%h exp=%h", log_q[b+1].dx, mk_word(9, 1, 2));
            end
            total++;
            if ({log_q[b+2].a, log_q[b+2].dx[31:0], log_q[b+2].dy[31:0]} !== {32'd0, 32'd10, 32'd1}) begin
                bad++;
                $display("FAIL part_header got=a%0d cnt%0d exp=a0 cnt10", log_q[b+2].a, log_q[b+2].dx[31:0]);
            end
        end
        total++;
        if (fl_cnt - f !== 1) begin
            bad++;
            $display("FAIL part_pulse got=%0d exp=1", fl_cnt - f);
        end
    endtask

    task automatic test_overflow();
        int b, f;
        b = log_q.size(); f = fl_cnt;
        start_frame();
        for (int i = 0; i < 20; i++) send(N'(i + 1), N'(i + 'h101), N'(i + 'h201), i == 19);
        repeat (5) tick();
        total++;
        if (log_q.size() - b !== 3) begin
            bad++;
            $display("FAIL ovf_nwr got=%0d exp=3", log_q.size() - b);
        end
        if (log_q.size() - b >= 3) begin
            total++;
            if ({log_q[b+1].a, log_q[b+1].dx} !== {32'd2, mk_word(9, 1, 8)}) begin
                bad++;
                $display("FAIL ovf_word2 got=a%0d %h exp=a2 %h", log_q[b+1].a, log_q[b+1].dx, mk_word(9, 1, 8));
            end
            total++;
            if ({log_q[b+2].a, log_q[b+2].dx[31:0]} !== {32'd0, 32'd16}) begin
                bad++;
                $display("FAIL ovf_header got=a%0d cnt%0d exp=a0 cnt16", log_q[b+2].a, log_q[b+2].dx[31:0]);
            end
        end
        total++;
        if ({fl_cnt - f, point_count, overflow} !== {32'd1, 32'd16, 1'b1}) begin
            bad++;
            $display("FAIL ovf_status got=fl%0d cnt%0d ov%b exp=fl1 cnt16 ov1", fl_cnt - f, point_count, overflow);
        end
    endtask

    task automatic test_zero_point();
        int b, f;
        b = log_q.size(); f = fl_cnt;
        start_frame();
        send('0, '0, '0, 1'b1);
        repeat (6) tick();
`ifdef PCL_ZERO_DROP_EN
        total++;
        if ({log_q.size() - b, fl_cnt - f, point_count} !== {32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL zero_drop got=wr%0d fl%0d cnt%0d exp=0/0/0", log_q.size() - b, fl_cnt - f, point_count);
        end
`else
        total++;
        if ({log_q.size() - b, fl_cnt - f, point_count} !== {32'd2, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL zero_keep got=wr%0d fl%0d cnt%0d exp=2/1/1", log_q.size() - b, fl_cnt - f, point_count);
        end
        if (log_q.size() - b >= 2) begin
            total++;
            if ({log_q[b].a, log_q[b].wx, log_q[b].dx, log_q[b].dy, log_q[b].dz} !==
                {32'd1, 16'hffff, {(3*W){1'b0}}}) begin
                bad++;
                $display("FAIL zero_word got=a%0d we%h %h exp=a1 weffff 0", log_q[b].a, log_q[b].wx, log_q[b].dx);
            end
            total++;
            if ({log_q[b+1].a, log_q[b+1].dx[31:0], log_q[b+1].dy[31:0]} !== {32'd0, 32'd1, 32'd1}) begin
                bad++;
                $display("FAIL zero_header got=a%0d cnt%0d exp=a0 cnt1", log_q[b+1].a, log_q[b+1].dx[31:0]);
            end
        end
`endif
    endtask

    task automatic test_idle_gate();
        int b;
        b = log_q.size();
        consumer_idle = 1'b0;
        s_valid = 1'b1; s_x = 16'h55; s_y = 16'h66; s_z = 16'h77;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (s_ready !== 1'b0) begin
                bad++;
                $display("FAIL gate_ready cyc%0d got=%b exp=0", i, s_ready);
            end
        end
        s_valid = 1'b0;
        total++;
        if (log_q.size() - b !== 0) begin
            bad++;
            $display("FAIL gate_writes got=%0d exp=0", log_q.size() - b);
        end
    endtask

    task automatic test_reset_abort();
        int b, f;
        b = log_q.size(); f = fl_cnt;
        start_frame();
        for (int i = 0; i < 5; i++) send(N'(i + 1), N'(i + 2), N'(i + 3), 1'b0);
        total++;
        if (point_count !== 32'd5) begin
            bad++;
            $display("FAIL abort_precount got=%0d exp=5", point_count);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({s_ready, en, frame_loaded, overflow, point_count, addr} !== '0) begin
            bad++;
            $display("FAIL abort_outputs got=rdy%b en%b cnt%0d exp=0", s_ready, en, point_count);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        total++;
        if ({log_q.size() - b, fl_cnt - f} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL abort_writes got=wr%0d fl%0d exp=0/0", log_q.size() - b, fl_cnt - f);
        end
    endtask

    task automatic test_valid_toggle();
        int b;
        b = log_q.size();
        start_frame();
        for (int k = 0; k < 8; k++) begin
            send(N'('h1000 + k * 'h11), N'('h2000 + k), N'('h3000 + k * 3), k == 7);
            tick();
        end
        repeat (4) tick();
        total++;
        if (log_q.size() - b !== 2) begin
            bad++;
            $display("FAIL tog_nwr got=%0d exp=2", log_q.size() - b);
        end
        if (log_q.size() - b >= 2) begin
            total++;
            if ({log_q[b].a, log_q[b].dx, log_q[b].dy, log_q[b].dz} !==
                {32'd1, mk_word('h1000, 'h11, 8), mk_word('h2000, 1, 8), mk_word('h3000, 3, 8)}) begin
                bad++;
                $display("FAIL tog_word got=a%0d %h exp=a1 %h", log_q[b].a, log_q[b].dx, mk_word('h1000, 'h11, 8));
            end
            total++;
            if ({log_q[b+1].a, log_q[b+1].dx[31:0]} !== {32'd0, 32'd8}) begin
                bad++;
                $display("FAIL tog_header got=a%0d cnt%0d exp=a0 cnt8", log_q[b+1].a, log_q[b+1].dx[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial_flush();
        test_overflow();
        test_zero_point();
        test_idle_gate();
        test_reset_abort();
        test_valid_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
